// File: rtl/btn_pkg.sv
// Shared constants for the watch push-button front end: channel indices,
// channel count and default debounce / auto-repeat timing.
package btn_pkg;

  localparam int NBTN = 6;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_ENTER = 4;
  localparam int BTN_ESC   = 5;

  localparam int DB_CYCLES_DEF    = 16;
  localparam int REPEAT_DELAY_DEF = 500;
  localparam int REPEAT_RATE_DEF  = 100;

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, counter debounce, press/release pulses.
// Auto-repeat of the press pulse is built only when BTN_COND_REPEAT_EN is defined.
module btn_chan
  import btn_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_lvl,
  output logic o_press,
  output logic o_rel
);

  localparam int             CW     = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  DB_MAX = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_cfg
    $error("btn_chan: illegal timing parameters");
  end

  logic [1:0]    r_sync;
  logic [CW-1:0] r_db;
  logic          r_lvl;
  logic          r_press;
  logic          r_rel;
  logic          w_diff;
  logic          w_flip;
  logic          w_rpt;

  // The counter only ever reaches DB_MAX before clearing, so it cannot wrap.
  assign w_diff = r_sync[1] != r_lvl;
  assign w_flip = w_diff && (r_db == DB_MAX);

`ifdef BTN_COND_REPEAT_EN
  localparam int            HW          = $clog2(REPEAT_DELAY + 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE);

  logic [HW-1:0] r_hold;

  // Reloading to DELAY-RATE makes every later repeat land RATE cycles apart.
  assign w_rpt = r_lvl && !w_flip && (r_hold == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (!r_lvl || w_flip) begin
      r_hold <= '0;
    end else if (w_rpt) begin
      r_hold <= HOLD_RELOAD;
    end else begin
      r_hold <= r_hold + HW'(1);
    end
  end
`else
  assign w_rpt = 1'b0;
`endif

  // NOTE: state flops use non-blocking assignments so every register in the
  // block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_db    <= '0;
      r_lvl   <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], ~i_btn_n};
      r_db    <= (!w_diff || w_flip) ? '0 : r_db + CW'(1);
      r_lvl   <= w_flip ? ~r_lvl : r_lvl;
      r_press <= (w_flip && !r_lvl) || w_rpt;
      r_rel   <= w_flip && r_lvl;
    end
  end

  assign o_lvl   = r_lvl;
  assign o_press = r_press;
  assign o_rel   = r_rel;

endmodule

// File: rtl/btn_cond.sv
// Button conditioner top: NBTN independent btn_chan instances, no priority.
// Optional auto-repeat of press pulses is enabled by BTN_COND_REPEAT_EN.
module btn_cond #(
  parameter int NBTN         = btn_pkg::NBTN,
  parameter int DB_CYCLES    = btn_pkg::DB_CYCLES_DEF,
  parameter int REPEAT_DELAY = btn_pkg::REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = btn_pkg::REPEAT_RATE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_n_i,
  output logic [NBTN-1:0] btn_lvl_o,
  output logic [NBTN-1:0] btn_press_o,
  output logic [NBTN-1:0] btn_rel_o
);

  for (genvar i = 0; i < NBTN; i++) begin : g_chan
    btn_chan #(
      .DB_CYCLES   (DB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .i_btn_n(btn_n_i[i]),
      .o_lvl  (btn_lvl_o[i]),
      .o_press(btn_press_o[i]),
      .o_rel  (btn_rel_o[i])
    );
  end

endmodule

// File: tb/tb_btn_cond.sv
// Scoreboard bench for btn_cond: directed scenarios plus random bouncy buttons,
// checked against a window-based model of the debounce and repeat rules.
module tb_btn_cond;
  import btn_pkg::*;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [NBTN-1:0] btn_n;
  logic [NBTN-1:0] lvl;
  logic [NBTN-1:0] press;
  logic [NBTN-1:0] rel;

  always #5 clk = ~clk;

  btn_cond #(
    .NBTN(NBTN), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n_i    (btn_n),
    .btn_lvl_o  (lvl),
    .btn_press_o(press),
    .btn_rel_o  (rel)
  );

  typedef struct packed {
    logic [NBTN-1:0] lvl;
    logic [NBTN-1:0] press;
    logic [NBTN-1:0] rel;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [NBTN-1:0] act, input logic [NBTN-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
  endtask

  // Reference model: a level is accepted once the last DB synchronised samples
  // (raw input two cycles old) all disagree with it; repeats at t+RD+m*RR.
  logic [NBTN-1:0] m_hist[0:DB+1];
  logic [NBTN-1:0] m_lvl = '0;
  int              m_cyc = 0;
  int              m_tpress[NBTN];

  task automatic model_step(input logic r, input logic [NBTN-1:0] bn, output exp_t e);
    logic nl;
    logic settled;
    m_cyc++;
    e = '0;
    if (r) begin
      for (int j = 0; j <= DB + 1; j++) m_hist[j] = '0;
      m_lvl = '0;
      return;
    end
    for (int j = DB + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = ~bn;
    for (int i = 0; i < NBTN; i++) begin
      settled = 1'b1;
      for (int j = 2; j <= DB + 1; j++)
        if (m_hist[j][i] == m_lvl[i]) settled = 1'b0;
      nl = settled ? ~m_lvl[i] : m_lvl[i];
      e.lvl[i] = nl;
      if (nl && !m_lvl[i]) begin
        e.press[i]  = 1'b1;
        m_tpress[i] = m_cyc;
      end
      if (!nl && m_lvl[i]) e.rel[i] = 1'b1;
`ifdef BTN_COND_REPEAT_EN
      if (nl && m_lvl[i]) begin
        int age;
        age = m_cyc - m_tpress[i];
        if (age >= RD && (age - RD) % RR == 0) e.press[i] = 1'b1;
      end
`endif
    end
    m_lvl = e.lvl;
  endtask

  // Stimulus: drive on the falling edge, queue the response expected after the
  // following rising edge.
  task automatic drive(input logic r, input logic [NBTN-1:0] bn);
    exp_t e;
    @(negedge clk);
    rst   = r;
    btn_n = bn;
    model_step(r, bn, e);
    @(posedge clk);
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so each falling edge presents one result.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("lvl",   lvl,   e.lvl);
      check("press", press, e.press);
      check("rel",   rel,   e.rel);
    end
  end

  initial begin
    logic [NBTN-1:0] cur;
    rst   = 1'b1;
    btn_n = '1;
    for (int j = 0; j <= DB + 1; j++) m_hist[j] = '0;

    repeat (3)  drive(1'b1, '1);
    repeat (50) drive(1'b0, '1);

    // single press on UP, then release
    cur = '1;
    cur[BTN_UP] = 1'b0;
    repeat (30) drive(1'b0, cur);
    cur[BTN_UP] = 1'b1;
    repeat (12) drive(1'b0, cur);

    // ENTER bouncing every 2 cycles must never be accepted
    for (int c = 0; c < 20; c++) begin
      cur[BTN_ENTER] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
      drive(1'b0, cur);
    end
    cur[BTN_ENTER] = 1'b1;
    repeat (10) drive(1'b0, cur);

    // DOWN and ESC pressed and released together
    cur[BTN_DOWN] = 1'b0;
    cur[BTN_ESC]  = 1'b0;
    repeat (15) drive(1'b0, cur);
    cur[BTN_DOWN] = 1'b1;
    cur[BTN_ESC]  = 1'b1;
    repeat (12) drive(1'b0, cur);

    // LEFT held through a one-cycle reset counts as a new press
    cur[BTN_LEFT] = 1'b0;
    repeat (10) drive(1'b0, cur);
    drive(1'b1, cur);
    repeat (12) drive(1'b0, cur);
    cur[BTN_LEFT] = 1'b1;
    repeat (10) drive(1'b0, cur);

    // long hold on UP to exercise auto-repeat when built in
    cur[BTN_UP] = 1'b0;
    repeat (46) drive(1'b0, cur);
    cur[BTN_UP] = 1'b1;
    repeat (20) drive(1'b0, cur);

    // random: channel 0 very bouncy, higher channels progressively calmer
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NBTN; i++)
        if ($urandom_range(0, 2 + i * 8) == 0) cur[i] = ~cur[i];
      drive($urandom_range(0, 399) == 0, cur);
    end
    repeat (12) drive(1'b0, '1);

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d results still queued, expected 0", sb_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
